pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_sup_pkg.sv | 18 +
 rtl/pll_lock_supervisor_sync_2ff.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 147 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared state encoding, counter widths and a saturating-increment helper
// for the PLL lock supervisor.
package pll_sup_pkg;

    localparam int CNT_W  = 16;
    localparam int STAT_W = 8;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        STABLE_CHK = 2'd1,
        RUN        = 2'd2
    } pll_state_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchronizer used to bring the asynchronous PLL lock into clk_div.
module sync_2ff (
    input  logic clk_div,
    input  logic sys_rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_div or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies PLL lock over a stability window before releasing downstream reset,
// and keeps sticky statistics on lock losses and lock-acquire timeouts.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned LOCK_STABLE = 16,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic              clk_div,
    input  logic              sys_rst_n,
    input  logic              locked,
    input  logic              clr_stat,
    output logic              rst_out_n,
    output logic              lock_ok,
    output logic [1:0]        state,
    output logic              timeout_flag,
    output logic [STAT_W-1:0] lost_cnt,
    output logic [STAT_W-1:0] timeout_cnt
);

    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    logic              lock_sync;
    pll_state_e        state_q;
    logic [CNT_W-1:0]  stab_cnt_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              rst_out_q;
    logic              lock_ok_q;
    logic              timeout_flag_q, timeout_flag_d;
    logic [STAT_W-1:0] lost_cnt_q, lost_cnt_d;
    logic [STAT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic              loss_evt;
    logic              timeout_evt;

    sync_2ff u_lock_sync (
        .clk_div   (clk_div),
        .sys_rst_n (sys_rst_n),
        .d_i       (locked),
        .q_o       (lock_sync)
    );

    // Outputs are decoded from the next state so they change on the same edge as state_q.
    always_ff @(posedge clk_div or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= WAIT_LOCK;
            stab_cnt_q <= '0;
            wait_cnt_q <= '0;
            rst_out_q  <= 1'b0;
            lock_ok_q  <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    rst_out_q <= 1'b0;
                    lock_ok_q <= 1'b0;
                    if (lock_sync) begin
                        state_q    <= STABLE_CHK;
                        stab_cnt_q <= '0;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                STABLE_CHK: begin
                    if (!lock_sync) begin
                        state_q    <= WAIT_LOCK;
                        stab_cnt_q <= '0;
                        wait_cnt_q <= '0;
                        rst_out_q  <= 1'b0;
                        lock_ok_q  <= 1'b0;
                    end else if (stab_cnt_q == STAB_LAST) begin
                        state_q   <= RUN;
                        rst_out_q <= 1'b1;
                        lock_ok_q <= 1'b1;
                    end else begin
                        stab_cnt_q <= stab_cnt_q + CNT_W'(1);
                        rst_out_q  <= 1'b0;
                        lock_ok_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!lock_sync) begin
                        state_q    <= WAIT_LOCK;
                        stab_cnt_q <= '0;
                        wait_cnt_q <= '0;
                        rst_out_q  <= 1'b0;
                        lock_ok_q  <= 1'b0;
                    end else begin
                        rst_out_q <= 1'b1;
                        lock_ok_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= WAIT_LOCK;
                    stab_cnt_q <= '0;
                    wait_cnt_q <= '0;
                    rst_out_q  <= 1'b0;
                    lock_ok_q  <= 1'b0;
                end
            endcase
        end
    end

    // A clear in the same cycle as a loss/timeout event discards the event.
    always_comb begin
        loss_evt       = (state_q == RUN) && !lock_sync;
        timeout_evt    = (state_q == WAIT_LOCK) && !lock_sync && (wait_cnt_q == WAIT_LAST);
        lost_cnt_d     = lost_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;
        timeout_flag_d = timeout_flag_q;
        if (clr_stat) begin
            lost_cnt_d     = '0;
            timeout_cnt_d  = '0;
            timeout_flag_d = 1'b0;
        end else begin
            if (loss_evt) begin
                lost_cnt_d = sat_inc(lost_cnt_q);
            end
            if (timeout_evt) begin
                timeout_cnt_d  = sat_inc(timeout_cnt_q);
                timeout_flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_div or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lost_cnt_q     <= '0;
            timeout_cnt_q  <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            lost_cnt_q     <= lost_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign rst_out_n    = rst_out_q;
    assign lock_ok      = lock_ok_q;
    assign state        = state_q;
    assign timeout_flag = timeout_flag_q;
    assign lost_cnt     = lost_cnt_q;
    assign timeout_cnt  = timeout_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with LOCK_STABLE=4, TIMEOUT=20.
module tb_pll_lock_supervisor;

    localparam int LS = 4;
    localparam int TO = 20;

    logic       clk_div = 1'b0;
    logic       sys_rst_n;
    logic       locked;
    logic       clr_stat;
    logic       rst_out_n;
    logic       lock_ok;
    logic [1:0] state;
    logic       timeout_flag;
    logic [7:0] lost_cnt;
    logic [7:0] timeout_cnt;

    int errors = 0;
    int checks = 0;

    pll_lock_supervisor #(.LOCK_STABLE(LS), .TIMEOUT(TO)) dut (
        .clk_div      (clk_div),
        .sys_rst_n    (sys_rst_n),
        .locked       (locked),
        .clr_stat     (clr_stat),
        .rst_out_n    (rst_out_n),
        .lock_ok      (lock_ok),
        .state        (state),
        .timeout_flag (timeout_flag),
        .lost_cnt     (lost_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    always #5 clk_div = ~clk_div;

    // Advance n rising edges and return 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_div);
        #1;
    endtask

    task automatic doReset();
        sys_rst_n = 1'b0;
        locked    = 1'b0;
        clr_stat  = 1'b0;
        tick(2);
        sys_rst_n = 1'b1;
    endtask

    task automatic waitRun(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (n < 40 && !ok) begin
            if (rst_out_n === 1'b1) ok = 1'b1;
            else begin
                tick(1);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        locked    = 1'b0;
        clr_stat  = 1'b0;
        #2;
        checks++;
        if ({state, rst_out_n, lock_ok, timeout_flag, lost_cnt, timeout_cnt} !== 21'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got state=%0d rst=%b ok=%b flag=%b lost=%0d to=%0d, want all 0",
                     state, rst_out_n, lock_ok, timeout_flag, lost_cnt, timeout_cnt);
        end
    endtask

    task automatic test_lock_acquire();
        doReset();
        locked = 1'b1;
        tick(2);
        checks++;
        if (state !== 2'd0) begin errors++; $display("[TB] FAIL acq_edge2_state: got %0d want 0", state); end
        tick(1);
        checks++;
        if (state !== 2'd1) begin errors++; $display("[TB] FAIL acq_edge3_state: got %0d want 1", state); end
        tick(3);
        checks++;
        if ({state, rst_out_n, lock_ok} !== {2'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL acq_edge6: got state=%0d rst=%b ok=%b want 1,0,0", state, rst_out_n, lock_ok);
        end
        tick(1);
        checks++;
        if ({state, rst_out_n, lock_ok} !== {2'd2, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL acq_edge7: got state=%0d rst=%b ok=%b want 2,1,1", state, rst_out_n, lock_ok);
        end
        checks++;
        if ({lost_cnt, timeout_cnt, timeout_flag} !== 17'd0) begin
            errors++;
            $display("[TB] FAIL acq_counters: got lost=%0d to=%0d flag=%b want 0", lost_cnt, timeout_cnt, timeout_flag);
        end
    endtask

    task automatic test_stable_abort();
        doReset();
        locked = 1'b1;
        tick(3);
        locked = 1'b0;
        tick(2);
        checks++;
        if (state !== 2'd1) begin errors++; $display("[TB] FAIL abort_in_chk_state: got %0d want 1", state); end
        tick(1);
        checks++;
        if ({state, rst_out_n} !== {2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL abort_back_wait: got state=%0d rst=%b want 0,0", state, rst_out_n);
        end
        tick(3);
        checks++;
        if ({state, rst_out_n, lost_cnt, timeout_cnt} !== 19'd0) begin
            errors++;
            $display("[TB] FAIL abort_settled: got state=%0d rst=%b lost=%0d to=%0d want 0",
                     state, rst_out_n, lost_cnt, timeout_cnt);
        end
    endtask

    task automatic test_timeout_and_clear();
        doReset();
        tick(TO - 1);
        checks++;
        if ({timeout_flag, timeout_cnt} !== 9'd0) begin
            errors++;
            $display("[TB] FAIL to_before: got flag=%b cnt=%0d want 0,0", timeout_flag, timeout_cnt);
        end
        tick(1);
        checks++;
        if ({timeout_flag, timeout_cnt} !== {1'b1, 8'd1}) begin
            errors++;
            $display("[TB] FAIL to_first: got flag=%b cnt=%0d want 1,1", timeout_flag, timeout_cnt);
        end
        tick(25);
        checks++;
        if ({timeout_flag, timeout_cnt, state} !== {1'b1, 8'd2, 2'd0}) begin
            errors++;
            $display("[TB] FAIL to_45: got flag=%b cnt=%0d state=%0d want 1,2,0", timeout_flag, timeout_cnt, state);
        end
        clr_stat = 1'b1;
        tick(1);
        clr_stat = 1'b0;
        checks++;
        if ({timeout_flag, timeout_cnt, lost_cnt} !== 17'd0) begin
            errors++;
            $display("[TB] FAIL to_clear: got flag=%b to=%0d lost=%0d want 0", timeout_flag, timeout_cnt, lost_cnt);
        end
    endtask

    task automatic test_lost_saturation();
        bit ok;
        int expLost;
        doReset();
        locked = 1'b1;
        tick(LS + 3);
        checks++;
        if (state !== 2'd2) begin errors++; $display("[TB] FAIL sat_start_run: got %0d want 2", state); end
        for (int ep = 0; ep < 300; ep++) begin
            expLost = (ep + 1 > 255) ? 255 : ep + 1;
            locked = 1'b0;
            tick(1);
            locked = 1'b1;
            tick(1);
            checks++;
            if (rst_out_n !== 1'b1) begin
                errors++;
                $display("[TB] FAIL loss_early_drop ep%0d: got rst=%b want 1", ep, rst_out_n);
            end
            tick(1);
            checks++;
            if ({rst_out_n, lock_ok, state} !== {1'b0, 1'b0, 2'd0}) begin
                errors++;
                $display("[TB] FAIL loss_drop ep%0d: got rst=%b ok=%b state=%0d want 0,0,0", ep, rst_out_n, lock_ok, state);
            end
            checks++;
            if (lost_cnt !== 8'(expLost)) begin
                errors++;
                $display("[TB] FAIL lost_cnt ep%0d: got %0d want %0d", ep, lost_cnt, expLost);
            end
            waitRun(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL relock_timeout ep%0d: rst_out_n never rose", ep);
                return;
            end
        end
        checks++;
        if (lost_cnt !== 8'd255) begin errors++; $display("[TB] FAIL lost_saturated: got %0d want 255", lost_cnt); end
    endtask

    task automatic test_clear_wins();
        bit ok;
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(1);
        clr_stat = 1'b1;
        tick(1);
        clr_stat = 1'b0;
        checks++;
        if ({lost_cnt, state, rst_out_n} !== {8'd0, 2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL clear_wins: got lost=%0d state=%0d rst=%b want 0,0,0", lost_cnt, state, rst_out_n);
        end
        waitRun(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL clear_relock: rst_out_n never rose"); end
    endtask

    task automatic test_reset_in_run();
        bit ok;
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(2);
        checks++;
        if (lost_cnt !== 8'd1) begin errors++; $display("[TB] FAIL pre_reset_lost: got %0d want 1", lost_cnt); end
        waitRun(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL pre_reset_relock: rst_out_n never rose"); return; end
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({rst_out_n, lock_ok, state, lost_cnt, timeout_cnt, timeout_flag} !== 21'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got rst=%b ok=%b state=%0d lost=%0d to=%0d flag=%b want 0",
                     rst_out_n, lock_ok, state, lost_cnt, timeout_cnt, timeout_flag);
        end
        tick(1);
        sys_rst_n = 1'b1;
        tick(LS + 2);
        checks++;
        if ({rst_out_n, state} !== {1'b0, 2'd1}) begin
            errors++;
            $display("[TB] FAIL rerelease_edge6: got rst=%b state=%0d want 0,1", rst_out_n, state);
        end
        tick(1);
        checks++;
        if ({rst_out_n, lock_ok, state} !== {1'b1, 1'b1, 2'd2}) begin
            errors++;
            $display("[TB] FAIL rerelease_edge7: got rst=%b ok=%b state=%0d want 1,1,2", rst_out_n, lock_ok, state);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_lock_acquire();
        test_stable_abort();
        test_timeout_and_clear();
        test_lost_saturation();
        test_clear_wins();
        test_reset_in_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
